stack_scheduler: RTL

//  Schedules and serialises the 48-bit sensor data stacks (geiger, temperature, pressure, aux) onto one downlink/storage port.

---
 rtl/stack_scheduler_pkg.sv | 22 ++
 rtl/stack_rr_arb.sv | 20 ++
 rtl/stack_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/stack_scheduler_pkg.sv
// Shared definitions for the sensor stack scheduler: stack geometry, FSM states, channel IDs.
package stack_scheduler_pkg;

  localparam int STACK_W = 48;
  localparam int NCH     = 4;
  localparam int CH_W    = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  localparam logic [CH_W-1:0] CH_GEIG = 2'd0;
  localparam logic [CH_W-1:0] CH_TEMP = 2'd1;
  localparam logic [CH_W-1:0] CH_PRES = 2'd2;
  localparam logic [CH_W-1:0] CH_AUX  = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/stack_rr_arb.sv
// Round-robin picker: first pending channel strictly after the pointer, wrapping.
module stack_rr_arb
  import stack_scheduler_pkg::*;
(
  input  logic [NCH-1:0]  pend_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [CH_W-1:0] grant_o,
  output logic            any_o
);

  // Scan farthest-first so the nearest pending channel after the pointer wins.
  always_comb begin
    grant_o = ptr_i;
    any_o   = |pend_i;
    for (int k = NCH; k >= 1; k--) begin
      if (pend_i[ptr_i + CH_W'(k)]) grant_o = ptr_i + CH_W'(k);
    end
  end

endmodule

// File: rtl/stack_scheduler.sv
// Sensor stack scheduler: periodic sample requests, one-deep hold buffers, RR-arbitrated output.
// Optional per-channel saturating drop counters when STACK_DROP_CNT_EN is defined.
module stack_scheduler
  import stack_scheduler_pkg::*;
#(
  parameter int PERIOD0 = 600,
  parameter int PERIOD1 = 10,
  parameter int PERIOD2 = 50,
  parameter int PERIOD3 = 100,
  parameter int TIMEOUT = 20,
  parameter int CNT_W   = 10
) (
  input  logic                   CLK_10HZ,
  input  logic                   RESET,
  input  logic [NCH*STACK_W-1:0] STACK_IN,
  input  logic [NCH-1:0]         IN_VALID,
  output logic [NCH-1:0]         SAMPLE_REQ,
  output logic [STACK_W-1:0]     STACK_OUT,
  output logic [CH_W-1:0]        OUT_CH,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  input  logic                   DROP_CLR,
  output logic [NCH-1:0]         DROP_FLAGS,
  output logic                   TIMEOUT_FLAG
`ifdef STACK_DROP_CNT_EN
  ,
  output logic [NCH*8-1:0]       DROP_CNT
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  function automatic logic [CNT_W-1:0] last_count(input int n);
    int p;
    case (n)
      0:       p = PERIOD0;
      1:       p = PERIOD1;
      2:       p = PERIOD2;
      default: p = PERIOD3;
    endcase
    return CNT_W'(p - 1);
  endfunction

  logic [CNT_W-1:0]   cnt_q [NCH];
  logic [NCH-1:0]     req_q;
  logic [STACK_W-1:0] hold_q [NCH];
  logic [NCH-1:0]     pend_q, pend_d;
  state_e             state_q;
  logic [CH_W-1:0]    ptr_q, ch_q;
  logic [STACK_W-1:0] out_q;
  logic               vld_q;
  logic [TMO_W-1:0]   tmo_q;
  logic [NCH-1:0]     drop_flags_q, drop_flags_d;
  logic               tmo_flag_q, tmo_flag_d;

  logic [CH_W-1:0]    gnt;
  logic               arb_any;
  logic               grant_en;
  logic [NCH-1:0]     gnt_vec;
  logic [NCH-1:0]     drop_ev;
  logic               timeout_ev;

  stack_rr_arb u_arb (
    .pend_i  (pend_q),
    .ptr_i   (ptr_q),
    .grant_o (gnt),
    .any_o   (arb_any)
  );

  // A channel granted on the same edge it captures is not an overwrite.
  always_comb begin
    grant_en     = (state_q == ST_IDLE) && arb_any;
    gnt_vec      = grant_en ? (NCH'(1) << gnt) : '0;
    drop_ev      = IN_VALID & pend_q & ~gnt_vec;
    timeout_ev   = (state_q == ST_PRESENT) && !OUT_READY && (tmo_q == TMO_W'(TIMEOUT - 1));
    pend_d       = (pend_q & ~gnt_vec) | IN_VALID;
    drop_flags_d = DROP_CLR ? drop_ev : (drop_flags_q | drop_ev);
    tmo_flag_d   = DROP_CLR ? timeout_ev : (tmo_flag_q | timeout_ev);
  end

  always_ff @(posedge CLK_10HZ or negedge RESET) begin
    if (!RESET) begin
      for (int n = 0; n < NCH; n++) cnt_q[n] <= '0;
      req_q <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (cnt_q[n] == last_count(n)) begin
          cnt_q[n] <= '0;
          req_q[n] <= 1'b1;
        end else begin
          cnt_q[n] <= cnt_q[n] + CNT_W'(1);
          req_q[n] <= 1'b0;
        end
      end
    end
  end

  // Hold buffers are pure data; pend_q qualifies them.
  always_ff @(posedge CLK_10HZ) begin
    for (int n = 0; n < NCH; n++) begin
      if (IN_VALID[n]) hold_q[n] <= STACK_IN[n*STACK_W +: STACK_W];
    end
  end

  always_ff @(posedge CLK_10HZ or negedge RESET) begin
    if (!RESET) begin
      pend_q       <= '0;
      drop_flags_q <= '0;
      tmo_flag_q   <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      drop_flags_q <= drop_flags_d;
      tmo_flag_q   <= tmo_flag_d;
    end
  end

  always_ff @(posedge CLK_10HZ or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      ptr_q   <= CH_AUX;
      ch_q    <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_en) begin
            out_q   <= hold_q[gnt];
            ch_q    <= gnt;
            vld_q   <= 1'b1;
            ptr_q   <= gnt;
            tmo_q   <= '0;
            state_q <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (OUT_READY || timeout_ev) begin
            vld_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef STACK_DROP_CNT_EN
  logic [7:0] dcnt_q [NCH];

  always_ff @(posedge CLK_10HZ or negedge RESET) begin
    if (!RESET) begin
      for (int n = 0; n < NCH; n++) dcnt_q[n] <= '0;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        if (drop_ev[n]) dcnt_q[n] <= sat_inc8(dcnt_q[n]);
      end
    end
  end

  for (genvar n = 0; n < NCH; n++) begin : g_dcnt
    assign DROP_CNT[n*8 +: 8] = dcnt_q[n];
  end
`endif

  assign SAMPLE_REQ   = req_q;
  assign STACK_OUT    = out_q;
  assign OUT_CH       = ch_q;
  assign OUT_VALID    = vld_q;
  assign DROP_FLAGS   = drop_flags_q;
  assign TIMEOUT_FLAG = tmo_flag_q;

endmodule
